// File: rtl/tqvp_pattern_sequencer_if.sv
// ---------------------------------------------------------------------------
// tqvp_pattern_sequencer_if
// Purpose : TinyQV peripheral bus bundle for the pattern sequencer.
// Signals : address      6   register address within the peripheral
//           data_in      32  write data (low 8/16/32 bits valid per data_write_n)
//           data_write_n 2   11 none, 00 byte, 01 half, 10 word
//           data_read_n  2   11 none, 00 byte, 01 half, 10 word
//           data_out     32  read data, combinational from address
//           data_ready   1   always 1, zero-wait-state accesses
// Modports: master (CPU side) drives address/data/strobes;
//           slave (peripheral side) returns data_out/data_ready.
// ---------------------------------------------------------------------------
interface tqvp_pattern_sequencer_if;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;

   modport master (
      output address, data_in, data_write_n, data_read_n,
      input  data_out, data_ready
   );

   modport slave (
      input  address, data_in, data_write_n, data_read_n,
      output data_out, data_ready
   );
endinterface

// File: rtl/tqvp_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tqvp_pattern_sequencer
// Purpose : TinyQV peripheral that walks uo_out through a table of
//           (pattern, duration) slots loaded by the CPU, optionally looping,
//           and flags completion of a one-shot run through DONE / interrupt.
// Ports   : clk             project clock
//           rst             asynchronous active-high reset
//           ui_in[7:0]      input PMOD (ui_in[1] is the start trigger when
//                           SEQ_TRIGGER_EN is defined, otherwise unused)
//           uo_out[7:0]     registered output pattern
//           bus             tqvp_pattern_sequencer_if.slave register bus
//           user_interrupt  DONE & IRQ_EN
// Config  : define SEQ_TRIGGER_EN to enable the CTRL.ARM hardware trigger.
// Reg map : 0x00 CTRL   [0]RUN [1]LOOP [2]IRQ_EN [3]ARM [10:8]LAST
//           0x04 STATUS [0]BUSY [1]DONE(W1C) [10:8]CUR_SLOT
//           0x08 IDLE_OUT[7:0]
//           0x20+4i SLOT i [7:0]PAT [8+DUR_W-1:8]DUR
// ---------------------------------------------------------------------------
module tqvp_pattern_sequencer #(
   parameter int NUM_SLOTS = 8,
   parameter int DUR_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   ui_in,
   output logic [7:0]                   uo_out,
   tqvp_pattern_sequencer_if.slave      bus,
   output logic                         user_interrupt
);

   localparam int         SLOT_W  = 8 + DUR_W;
   localparam logic [2:0] MAX_IDX = 3'(NUM_SLOTS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_q, state_d;
   logic [DUR_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          curSlot_q, curSlot_d;
   logic [7:0]          uo_q, uo_d;
   logic [7:0]          idleOut_q;
   logic [SLOT_W-1:0]   slot_q [NUM_SLOTS];
   logic                run_q, loop_q, irqEn_q, done_q;
   logic [2:0]          last_q;
   logic                armBit;
   logic                trigStart;

   logic                wrEn, ctrlSel, statusSel, idleSel, slotSel;
   logic                ctrlWr, statusWr, idleWr, slotWr;
   logic [2:0]          slotIdx, lastEff, loadIdx;
   logic [31:0]         wrMask, ctrlCur, ctrlNew, slotNew;
   logic                loadSlot, doneSet, runClr, startEvt;

   // Decode the register being addressed and the byte lanes a write covers.
   assign wrEn      = (bus.data_write_n != 2'b11);
   assign slotIdx   = bus.address[4:2];
   assign ctrlSel   = (bus.address == 6'h00);
   assign statusSel = (bus.address == 6'h04);
   assign idleSel   = (bus.address == 6'h08);
   assign slotSel   = bus.address[5] && (bus.address[1:0] == 2'b00) &&
                      (int'(slotIdx) < NUM_SLOTS);
   assign ctrlWr    = wrEn && ctrlSel;
   assign statusWr  = wrEn && statusSel;
   assign idleWr    = wrEn && idleSel;
   assign slotWr    = wrEn && slotSel;

   // Write lane mask: byte touches [7:0], half [15:0], word everything.
   always_comb begin
      wrMask = 32'h0;
      case (bus.data_write_n)
         2'b00:   wrMask = 32'h0000_00FF;
         2'b01:   wrMask = 32'h0000_FFFF;
         2'b10:   wrMask = 32'hFFFF_FFFF;
         default: wrMask = 32'h0;
      endcase
   end

   // Merged register images: untouched lanes keep their current contents.
   assign ctrlCur = {21'b0, last_q, 4'b0, armBit, irqEn_q, loop_q, run_q};
   assign ctrlNew = (ctrlCur & ~wrMask) | (bus.data_in & wrMask);
   assign slotNew = slotSel ? ((32'(slot_q[slotIdx]) & ~wrMask) | (bus.data_in & wrMask))
                            : 32'h0;

   // A LAST value beyond the table is treated as the final implemented slot.
   assign lastEff = (last_q > MAX_IDX) ? MAX_IDX : last_q;

`ifdef SEQ_TRIGGER_EN
   logic arm_q, uiPrev_q;

   // Remember ui_in[1] for one cycle so a 0->1 transition can be spotted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uiPrev_q <= 1'b0;
      end else begin
         uiPrev_q <= ui_in[1];
      end
   end

   assign armBit    = arm_q;
   assign trigStart = arm_q && ui_in[1] && !uiPrev_q;
`else
   assign armBit    = 1'b0;
   assign trigStart = 1'b0;
`endif

   // First countdown value for a slot: a slot always lasts at least one cycle,
   // so a zero duration behaves like one.
   function automatic logic [DUR_W-1:0] firstCnt(input logic [SLOT_W-1:0] s);
      logic [DUR_W-1:0] dur;
      dur = s[SLOT_W-1:8];
      return (dur == '0) ? '0 : dur - 1'b1;
   endfunction

   // Sequencer next-state logic. Every slot load (start, advance, loop wrap,
   // restart) goes through the shared loadSlot path at the bottom so the next
   // pattern appears on the same edge the previous one expires.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      curSlot_d = curSlot_q;
      uo_d      = uo_q;
      loadSlot  = 1'b0;
      loadIdx   = 3'd0;
      doneSet   = 1'b0;
      runClr    = 1'b0;
      startEvt  = 1'b0;
      case (state_q)
         IDLE: begin
            uo_d = idleOut_q;
            if ((ctrlWr && bus.data_in[0]) || trigStart) begin
               state_d  = RUN;
               loadSlot = 1'b1;
               startEvt = 1'b1;
            end
         end
         RUN: begin
            if (ctrlWr) begin
               if (bus.data_in[0]) begin
                  loadSlot = 1'b1;
               end else begin
                  state_d = IDLE;
                  uo_d    = idleOut_q;
               end
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (curSlot_q == lastEff) begin
               if (loop_q) begin
                  loadSlot = 1'b1;
               end else begin
                  doneSet = 1'b1;
                  runClr  = 1'b1;
                  state_d = IDLE;
                  uo_d    = idleOut_q;
               end
            end else begin
               loadSlot = 1'b1;
               loadIdx  = curSlot_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (loadSlot) begin
         uo_d      = slot_q[loadIdx][7:0];
         cnt_d     = firstCnt(slot_q[loadIdx]);
         curSlot_d = loadIdx;
      end
   end

   // Sequencer state, countdown, current slot and output pattern registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         curSlot_q <= 3'd0;
         uo_q      <= 8'h00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         curSlot_q <= curSlot_d;
         uo_q      <= uo_d;
      end
   end

   // Software-visible registers. RUN follows the last CTRL write, drops when a
   // one-shot finishes and rises on a hardware-triggered start. DONE is sticky
   // and a completion in the same cycle as a W1C beats the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q     <= 1'b0;
         loop_q    <= 1'b0;
         irqEn_q   <= 1'b0;
         last_q    <= 3'd0;
         done_q    <= 1'b0;
         idleOut_q <= 8'h00;
`ifdef SEQ_TRIGGER_EN
         arm_q     <= 1'b0;
`endif
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         if (ctrlWr) begin
            run_q   <= ctrlNew[0];
            loop_q  <= ctrlNew[1];
            irqEn_q <= ctrlNew[2];
            last_q  <= ctrlNew[10:8];
         end else if (runClr) begin
            run_q <= 1'b0;
         end else if (startEvt) begin
            run_q <= 1'b1;
         end
`ifdef SEQ_TRIGGER_EN
         if (startEvt) begin
            arm_q <= 1'b0;
         end else if (ctrlWr) begin
            arm_q <= ctrlNew[3];
         end
`endif
         if (doneSet) begin
            done_q <= 1'b1;
         end else if (statusWr && bus.data_in[1]) begin
            done_q <= 1'b0;
         end
         if (idleWr) begin
            idleOut_q <= bus.data_in[7:0];
         end
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slotWr && (int'(slotIdx) == i)) begin
               slot_q[i] <= slotNew[SLOT_W-1:0];
            end
         end
      end
   end

   // Read mux: full 32-bit register image, unmapped addresses read zero.
   always_comb begin
      bus.data_out = 32'h0;
      if (ctrlSel) begin
         bus.data_out = ctrlCur;
      end else if (statusSel) begin
         bus.data_out = {21'b0, curSlot_q, 6'b0, done_q, (state_q == RUN)};
      end else if (idleSel) begin
         bus.data_out = {24'b0, idleOut_q};
      end else if (slotSel) begin
         bus.data_out = 32'(slot_q[slotIdx]);
      end
   end

   assign bus.data_ready  = 1'b1;
   assign uo_out          = uo_q;
   assign user_interrupt  = done_q && irqEn_q;

   wire _unused = &{1'b0, bus.data_read_n, ui_in, ctrlNew, slotNew};

endmodule

// File: tb/tb_tqvp_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tqvp_pattern_sequencer
// Self-checking bench for tqvp_pattern_sequencer. Expected output streams are
// built from the slot table as plain lists of patterns (each repeated
// max(DUR,1) times) and compared cycle by cycle on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_tqvp_pattern_sequencer;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [5:0] A_CTRL  = 6'h00;
   localparam logic [5:0] A_STAT  = 6'h04;
   localparam logic [5:0] A_IDLE  = 6'h08;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic       user_interrupt;
   int         total = 0;
   int         bad = 0;

   tqvp_pattern_sequencer_if bus ();

   tqvp_pattern_sequencer #(.NUM_SLOTS(8), .DUR_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .ui_in          (ui_in),
      .uo_out         (uo_out),
      .bus            (bus),
      .user_interrupt (user_interrupt)
   );

   always #5 clk = ~clk;

   // Hard time limit so a broken design can never hang the run.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one write at a falling edge; returns at the falling edge after
   // the rising edge that captured it.
   task automatic busWrite(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
      bus.address      = a;
      bus.data_in      = d;
      bus.data_write_n = sz;
      @(negedge clk);
      bus.data_write_n = 2'b11;
   endtask

   // Combinational read; does not consume a clock edge.
   task automatic busRead(input logic [5:0] a, output logic [31:0] d);
      bus.address     = a;
      bus.data_read_n = SZ_WORD;
      #1;
      d = bus.data_out;
      bus.data_read_n = 2'b11;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      ui_in            = 8'h00;
      bus.address      = 6'h00;
      bus.data_in      = 32'h0;
      bus.data_write_n = 2'b11;
      bus.data_read_n  = 2'b11;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (uo_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_uo: got %h want 00", uo_out); end
      total++;
      if (user_interrupt !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %b want 0", user_interrupt); end
      total++;
      if (bus.data_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", bus.data_ready); end
      busRead(A_STAT, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_status: got %h want 0", rd); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_one_shot();
      logic [7:0]  expQ[$];
      logic [31:0] rd;
      busWrite(A_IDLE, 32'h5A, SZ_WORD);
      busWrite(6'h20, 32'h0000_03A5, SZ_WORD);
      busWrite(6'h24, 32'h0000_023C, SZ_WORD);
      busWrite(A_STAT, 32'h2, SZ_WORD);
      expQ = '{8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h3C};
      busWrite(A_CTRL, 32'h105, SZ_WORD);
      foreach (expQ[k]) begin
         total++;
         if (uo_out !== expQ[k]) begin bad++; $display("[TB] FAIL oneshot_uo[%0d]: got %h want %h", k, uo_out, expQ[k]); end
         @(negedge clk);
      end
      total++;
      if (uo_out !== 8'h5A) begin bad++; $display("[TB] FAIL oneshot_idle: got %h want 5a", uo_out); end
      busRead(A_STAT, rd);
      total++;
      if (rd[1:0] !== 2'b10) begin bad++; $display("[TB] FAIL oneshot_done: got %b want 10", rd[1:0]); end
      total++;
      if (user_interrupt !== 1'b1) begin bad++; $display("[TB] FAIL oneshot_irq: got %b want 1", user_interrupt); end
      busRead(A_CTRL, rd);
      total++;
      if (rd[0] !== 1'b0) begin bad++; $display("[TB] FAIL oneshot_run_clear: got %b want 0", rd[0]); end
      busWrite(A_STAT, 32'h2, SZ_WORD);
      total++;
      if (user_interrupt !== 1'b0) begin bad++; $display("[TB] FAIL oneshot_w1c_irq: got %b want 0", user_interrupt); end
   endtask

   task automatic test_dur_zero();
      logic [31:0] rd;
      busWrite(6'h20, 32'h0000_0011, SZ_WORD);
      busWrite(A_CTRL, 32'h001, SZ_WORD);
      total++;
      if (uo_out !== 8'h11) begin bad++; $display("[TB] FAIL dur0_uo: got %h want 11", uo_out); end
      @(negedge clk);
      total++;
      if (uo_out !== 8'h5A) begin bad++; $display("[TB] FAIL dur0_idle: got %h want 5a", uo_out); end
      busRead(A_STAT, rd);
      total++;
      if (rd[1:0] !== 2'b10) begin bad++; $display("[TB] FAIL dur0_done: got %b want 10", rd[1:0]); end
      total++;
      if (user_interrupt !== 1'b0) begin bad++; $display("[TB] FAIL dur0_irq_masked: got %b want 0", user_interrupt); end
      busWrite(A_STAT, 32'h2, SZ_BYTE);
   endtask

   task automatic test_loop_stop();
      logic [31:0] rd;
      logic [7:0]  want;
      busWrite(6'h20, 32'h0000_02A5, SZ_WORD);
      busWrite(6'h24, 32'h0000_023C, SZ_WORD);
      busWrite(A_CTRL, 32'h103, SZ_WORD);
      for (int k = 0; k < 12; k++) begin
         want = ((k % 4) < 2) ? 8'hA5 : 8'h3C;
         total++;
         if (uo_out !== want) begin bad++; $display("[TB] FAIL loop_uo[%0d]: got %h want %h", k, uo_out, want); end
         @(negedge clk);
      end
      busWrite(A_CTRL, 32'h0, SZ_WORD);
      total++;
      if (uo_out !== 8'h5A) begin bad++; $display("[TB] FAIL loop_stop_uo: got %h want 5a", uo_out); end
      busRead(A_STAT, rd);
      total++;
      if (rd[1:0] !== 2'b00) begin bad++; $display("[TB] FAIL loop_stop_status: got %b want 00", rd[1:0]); end
   endtask

   task automatic test_byte_write();
      logic [31:0] rd;
      busWrite(6'h20, 32'h0000_1234, SZ_WORD);
      busWrite(6'h20, 32'hABCD_EFFF, SZ_BYTE);
      busRead(6'h20, rd);
      total++;
      if (rd !== 32'h0000_12FF) begin bad++; $display("[TB] FAIL byte_write: got %h want 000012ff", rd); end
      busWrite(6'h20, 32'hFFFF_5678, SZ_HALF);
      busRead(6'h20, rd);
      total++;
      if (rd !== 32'h0000_5678) begin bad++; $display("[TB] FAIL half_write: got %h want 00005678", rd); end
      busWrite(6'h0C, 32'hFFFF_FFFF, SZ_WORD);
      busRead(6'h0C, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("[TB] FAIL unmapped_read: got %h want 0", rd); end
   endtask

   task automatic test_random();
      logic [7:0]  pat [8];
      int          dur [8];
      logic [31:0] raw;
      logic [31:0] rd;
      logic [7:0]  idleVal;
      logic [7:0]  expQ[$];
      int          last;
      logic        irqEn;
      for (int it = 0; it < 6; it++) begin
         for (int s = 0; s < 8; s++) begin
            pat[s] = 8'($urandom);
            dur[s] = $urandom_range(0, 4);
            raw = {8'($urandom), 16'(dur[s]), pat[s]};
            busWrite(6'h20 + 6'(4 * s), raw, SZ_WORD);
         end
         busRead(6'h20 + 6'(4 * (it % 8)), rd);
         total++;
         if (rd !== {8'h00, 16'(dur[it % 8]), pat[it % 8]}) begin
            bad++; $display("[TB] FAIL rand_slot_read[%0d]: got %h want %h", it, rd, {8'h00, 16'(dur[it % 8]), pat[it % 8]});
         end
         idleVal = 8'($urandom);
         last    = $urandom_range(0, 7);
         irqEn   = 1'($urandom);
         busWrite(A_IDLE, {24'h0, idleVal}, SZ_BYTE);
         busWrite(A_STAT, 32'h2, SZ_WORD);
         total++;
         if (uo_out !== idleVal) begin bad++; $display("[TB] FAIL rand_idle_pre[%0d]: got %h want %h", it, uo_out, idleVal); end
         expQ.delete();
         for (int s = 0; s <= last; s++) begin
            for (int c = 0; c < ((dur[s] == 0) ? 1 : dur[s]); c++) expQ.push_back(pat[s]);
         end
         busWrite(A_CTRL, 32'(last) << 8 | 32'(irqEn) << 2 | 32'h1, SZ_WORD);
         foreach (expQ[k]) begin
            total++;
            if (uo_out !== expQ[k]) begin bad++; $display("[TB] FAIL rand_uo[%0d.%0d]: got %h want %h", it, k, uo_out, expQ[k]); end
            @(negedge clk);
         end
         total++;
         if (uo_out !== idleVal) begin bad++; $display("[TB] FAIL rand_idle_post[%0d]: got %h want %h", it, uo_out, idleVal); end
         busRead(A_STAT, rd);
         total++;
         if (rd[1:0] !== 2'b10) begin bad++; $display("[TB] FAIL rand_status[%0d]: got %b want 10", it, rd[1:0]); end
         total++;
         if (user_interrupt !== irqEn) begin bad++; $display("[TB] FAIL rand_irq[%0d]: got %b want %b", it, user_interrupt, irqEn); end
      end
      busWrite(A_STAT, 32'h2, SZ_WORD);
   endtask

   task automatic test_reset_midrun();
      logic [31:0] rd;
      busWrite(6'h20, 32'h0000_02A5, SZ_WORD);
      busWrite(6'h24, 32'h0000_023C, SZ_WORD);
      busWrite(A_CTRL, 32'h107, SZ_WORD);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if (uo_out !== 8'h00) begin bad++; $display("[TB] FAIL midrst_uo: got %h want 00", uo_out); end
      total++;
      if (user_interrupt !== 1'b0) begin bad++; $display("[TB] FAIL midrst_irq: got %b want 0", user_interrupt); end
      total++;
      if (bus.data_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ready: got %b want 1", bus.data_ready); end
      busRead(A_STAT, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midrst_status: got %h want 0", rd); end
      busRead(A_CTRL, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midrst_ctrl: got %h want 0", rd); end
      busRead(6'h20, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midrst_slot0: got %h want 0", rd); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_trigger();
      logic [31:0] rd;
      logic        wantBusy;
`ifdef SEQ_TRIGGER_EN
      wantBusy = 1'b1;
`else
      wantBusy = 1'b0;
`endif
      busWrite(6'h20, 32'h0000_0581, SZ_WORD);
      ui_in = 8'h00;
      busWrite(A_CTRL, 32'h008, SZ_WORD);
      @(negedge clk);
      ui_in = 8'h02;
      @(negedge clk);
      busRead(A_STAT, rd);
      total++;
      if (rd[0] !== wantBusy) begin bad++; $display("[TB] FAIL trig_busy: got %b want %b", rd[0], wantBusy); end
      busRead(A_CTRL, rd);
      total++;
      if (rd[3] !== 1'b0) begin bad++; $display("[TB] FAIL trig_arm: got %b want 0", rd[3]); end
      total++;
      if (uo_out !== (wantBusy ? 8'h81 : 8'h00)) begin
         bad++; $display("[TB] FAIL trig_uo: got %h want %h", uo_out, wantBusy ? 8'h81 : 8'h00);
      end
      ui_in = 8'h00;
      busWrite(A_CTRL, 32'h0, SZ_WORD);
      busRead(A_STAT, rd);
      total++;
      if (rd[0] !== 1'b0) begin bad++; $display("[TB] FAIL trig_stop: got %b want 0", rd[0]); end
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_dur_zero();
      test_loop_stop();
      test_byte_write();
      test_random();
      test_reset_midrun();
      test_trigger();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
